// File: rtl/sdram_writer_pkg.sv
// Shared types and constants for the SDRAM stream writer and its FIFO.
package sdram_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] BYTEENABLE_ALL = 2'b11;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdram_stream_writer_if.sv
// Stream sink and Avalon-MM write-master signals of the SDRAM stream writer.
interface sdram_stream_writer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 24
);
  logic [DATA_W-1:0] sink_data;
  logic              sink_valid;
  logic              sink_ready;
  logic [ADDR_W:0]   avm_address;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [1:0]        avm_byteenable;
  logic              avm_waitrequest;

  modport master (
    input  sink_data, sink_valid, avm_waitrequest,
    output sink_ready, avm_address, avm_write, avm_writedata, avm_byteenable
  );

  modport slave (
    output sink_data, sink_valid, avm_waitrequest,
    input  sink_ready, avm_address, avm_write, avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty and synchronous clear.
module sync_fifo
  import sdram_writer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       wr_ptr_nxt;
  logic [AW:0]       rd_ptr_nxt;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is fine when the head leaves on the same edge.
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};
  assign head       = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
      full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/sdram_stream_writer.sv
// Buffers a 16-bit sample stream and writes a programmed number of words to
// consecutive SDRAM word addresses through an Avalon-MM write master.
//
// state | meaning
// IDLE  | waiting for start; parameters sampled and FIFO cleared on start
// RUN   | accepting stream words and issuing writes until out_left reaches 0
// DONE  | one-cycle completion pulse, then back to IDLE
module sdram_stream_writer
  import sdram_writer_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 24,
  parameter int LEN_W      = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  sdram_stream_writer_if.master bus
);

  state_t            state;
  logic [ADDR_W-1:0] wr_addr;
  logic [LEN_W-1:0]  in_left;
  logic [LEN_W-1:0]  out_left;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_clear;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  assign bus.sink_ready     = (state == RUN) && !fifo_full && (in_left != '0);
  assign push               = bus.sink_valid && bus.sink_ready;
  assign bus.avm_write      = (state == RUN) && !fifo_empty;
  assign pop                = bus.avm_write && !bus.avm_waitrequest;
  assign fifo_clear         = (state == IDLE) && start;
  assign bus.avm_address    = {wr_addr, 1'b0};
  // Data and byte enables are gated so the bus idles at zero outside writes.
  assign bus.avm_writedata  = bus.avm_write ? head : '0;
  assign bus.avm_byteenable = bus.avm_write ? BYTEENABLE_ALL : 2'b00;
  assign busy               = (state != IDLE);
  assign done               = (state == DONE);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .clear     (fifo_clear),
    .push      (push),
    .push_data (bus.sink_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state    <= IDLE;
      wr_addr  <= '0;
      in_left  <= '0;
      out_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            wr_addr  <= base_addr;
            in_left  <= length;
            out_left <= length;
          end
        end
        RUN: begin
          if (out_left == '0) begin
            state <= DONE;
          end
          if (push) begin
            in_left <= in_left - LEN_W'(1);
          end
          if (pop) begin
            wr_addr  <= wr_addr + ADDR_W'(1);
            out_left <= out_left - LEN_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_stream_writer.sv
// Scoreboard bench for sdram_stream_writer: directed transfers, stalls, wrap,
// zero length, surplus stream words and mid-transfer reset.
module tb_sdram_stream_writer;

  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        start;
  logic [23:0] base_addr;
  logic [23:0] length;
  logic        busy;
  logic        done;

  sdram_stream_writer_if #(.DATA_W(16), .ADDR_W(24)) bus ();

  sdram_stream_writer #(
    .DATA_W(16), .ADDR_W(24), .LEN_W(24), .FIFO_DEPTH(16)
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  always #5 clk_clk = ~clk_clk;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  accepted, wr_cnt, done_cnt, busy_cnt, ready_cnt, last_wr_cyc, done_cyc;
  bit  stop;

  always @(posedge clk_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_reset_vals();
    check("rst_busy",       64'(busy), 64'd0);
    check("rst_done",       64'(done), 64'd0);
    check("rst_sink_ready", 64'(bus.sink_ready), 64'd0);
    check("rst_avm_write",  64'(bus.avm_write), 64'd0);
    check("rst_avm_addr",   64'(bus.avm_address), 64'd0);
    check("rst_avm_data",   64'(bus.avm_writedata), 64'd0);
    check("rst_avm_be",     64'(bus.avm_byteenable), 64'd0);
  endtask

  // Monitor: every presented write is compared against the queue head; it is
  // popped only when the slave accepts, so stalled cycles must show the same word.
  always @(negedge clk_clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (bus.sink_ready === 1'b1) ready_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.avm_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual_addr=%0h required=no write", bus.avm_address);
      end else begin
        check("wr_addr", 64'(bus.avm_address), 64'(exp_q[0].addr));
        check("wr_data", 64'(bus.avm_writedata), 64'(exp_q[0].data));
        check("wr_be",   64'(bus.avm_byteenable), 64'd3);
        if (bus.avm_waitrequest === 1'b0) begin
          void'(exp_q.pop_front());
          wr_cnt++;
          last_wr_cyc = cyc;
        end
      end
    end
  end

  task automatic run(input logic [23:0] base, input int len, input int offer,
                     input int st_at, input int st_len, input bit chk_full,
                     input bit mid_start, input bit do_rst);
    int  stall_left;
    wr_t w;
    stall_left  = st_len;
    accepted    = 0;
    wr_cnt      = 0;
    done_cnt    = 0;
    busy_cnt    = 0;
    ready_cnt   = 0;
    last_wr_cyc = -1;
    done_cyc    = -1;
    stop        = 0;
    for (int i = 0; i < len; i++) begin
      w.addr = {base + 24'(i), 1'b0};
      w.data = 16'(32'h1000 + i);
      exp_q.push_back(w);
    end
    @(posedge clk_clk); #1;
    start = 1; base_addr = base; length = 24'(len);
    @(posedge clk_clk); #1;
    start = 0; base_addr = 24'hABCDEF; length = 24'hFFFFFF;
    fork
      begin
        int i;
        i = 0;
        while (!stop && i < offer) begin
          bus.sink_valid = 1;
          bus.sink_data  = 16'(32'h1000 + i);
          @(negedge clk_clk);
          if (bus.sink_ready) begin
            accepted++;
            i++;
          end
          @(posedge clk_clk); #1;
        end
        bus.sink_valid = 0;
      end
      begin
        while (!stop) begin
          @(posedge clk_clk); #1;
          if (!stop && stall_left > 0 && wr_cnt == st_at) begin
            bus.avm_waitrequest = 1;
            stall_left--;
            if (stall_left == 0 && chk_full) begin
              @(negedge clk_clk); #1;
              check("full_occupancy",  64'(accepted - wr_cnt), 64'd16);
              check("full_sink_ready", 64'(bus.sink_ready), 64'd0);
            end
          end else begin
            bus.avm_waitrequest = 0;
          end
        end
        if (!do_rst) bus.avm_waitrequest = 0;
      end
      begin
        int t;
        bit rst_done;
        t = 0;
        rst_done = 0;
        while (done_cnt == 0 && !rst_done && t < 600) begin
          @(negedge clk_clk); #2;
          t++;
          if (mid_start && t == 6) begin
            start = 1; base_addr = 24'h777777; length = 24'd3;
            @(posedge clk_clk); #1;
            start = 0;
          end
          if (do_rst && bus.avm_waitrequest && (accepted - wr_cnt) >= 6) begin
            reset_reset = 1;
            stop = 1;
            rst_done = 1;
            @(posedge clk_clk);
            @(negedge clk_clk);
            chk_reset_vals();
          end
        end
        stop = 1;
        if (do_rst) begin
          if (!rst_done) begin
            checks++; errors++;
            $display("FAIL reset_trigger_timeout actual=not reached required=6 buffered with stall");
          end
        end else begin
          if (done_cnt == 0) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=no done required=done pulse");
          end
          if (len > 0) check("done_latency", 64'(done_cyc - last_wr_cyc), 64'd2);
          @(negedge clk_clk);
          check("busy_after_done", 64'(busy), 64'd0);
          check("done_single", 64'(done_cnt), 64'd1);
        end
      end
    join
    if (do_rst) begin
      exp_q.delete();
      @(posedge clk_clk); #1;
      reset_reset = 0;
      bus.avm_waitrequest = 0;
    end else begin
      check("accepted_count", 64'(accepted), 64'(len));
      check("writes_count",   64'(wr_cnt), 64'(len));
      check("queue_drained",  64'(exp_q.size()), 64'd0);
      if (len == 0) begin
        check("len0_busy_cycles", 64'(busy_cnt), 64'd2);
        check("len0_no_ready",    64'(ready_cnt), 64'd0);
      end
    end
  endtask

  initial begin
    reset_reset = 1; start = 0; base_addr = 0; length = 0;
    bus.sink_valid = 0; bus.sink_data = 0; bus.avm_waitrequest = 0;
    repeat (3) @(posedge clk_clk);
    @(negedge clk_clk);
    chk_reset_vals();
    @(posedge clk_clk); #1;
    reset_reset = 0;

    run(24'h000100, 8,  8,  -1, 0,  0, 0, 0);   // plain burst
    run(24'h000100, 8,  8,  2,  5,  0, 0, 0);   // 5-cycle stall on 3rd write
    run(24'h000100, 24, 24, 2,  24, 1, 0, 0);   // long stall fills the FIFO
    run(24'h000200, 0,  0,  -1, 0,  0, 0, 0);   // zero length
    run(24'hFFFFFE, 4,  4,  -1, 0,  0, 0, 0);   // address wrap
    run(24'h000300, 12, 20, -1, 0,  0, 1, 0);   // surplus words, ignored start
    run(24'h000500, 12, 12, 2,  60, 0, 0, 1);   // reset while stalled
    run(24'h000400, 3,  3,  -1, 0,  0, 0, 0);   // clean run after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
